// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU-side initiator for the 8-bit program/data memory bus
//
// Accepts one read or write request at a time from the CPU core. Each request runs
// SETUP -> STROBE (W cycles) -> HOLD -> DONE on the memory bus. W = max(WAIT_CYCLES, 1).
// Transactions only run while cpustate == 2'b11 (RUN). Leaving RUN mid-transaction
// returns the bus to idle and pulses bus_abort.
//
// Parameters:
//   WAIT_CYCLES  strobe width in clk cycles (1..15, 0 behaves as 1)
//
// Optional build macro:
//   MEM_BUS_ROM_PROTECT_EN  suppresses write strobes to 0x0000-0x001F and adds rom_wr_err
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpustate              01=IN, 10=CHECK, 11=RUN
//   req_valid/req_ready   request handshake; req_write/req_addr/req_wdata sampled on accept
//   rsp_valid/rsp_rdata   one-cycle completion pulse and captured read data
//   bus_abort             one-cycle pulse when a transaction is cut short by leaving RUN
//   addr/read/write       memory address and strobes
//   data_out/data_in      memory write data / read data
//   rom_wr_err            (macro only) pulses with rsp_valid for a blocked ROM write

module mem_bus_master #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cpustate,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        bus_abort,
    output logic [15:0] addr,
    output logic        read,
    output logic        write,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in
`ifdef MEM_BUS_ROM_PROTECT_EN
    ,
    output logic        rom_wr_err
`endif
);

    localparam logic [3:0] W = (WAIT_CYCLES < 1) ? 4'd1 : 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;
    logic       rom_blk;
    logic       run;
    logic       rom_hit;

    assign run       = (cpustate == 2'b11);
    assign req_ready = (state == IDLE) && run && !reset;

`ifdef MEM_BUS_ROM_PROTECT_EN
    assign rom_hit = req_write && (req_addr[15:5] == 11'd0);
`else
    assign rom_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            rom_blk   <= 1'b0;
            addr      <= 16'h0000;
            data_out  <= 8'h00;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            bus_abort <= 1'b0;
`ifdef MEM_BUS_ROM_PROTECT_EN
            rom_wr_err <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; only HOLD or an abort raise them.
            rsp_valid <= 1'b0;
            bus_abort <= 1'b0;
`ifdef MEM_BUS_ROM_PROTECT_EN
            rom_wr_err <= 1'b0;
`endif
            if (state != IDLE && !run) begin
                // Leaving RUN wins over every phase, including DONE.
                state     <= IDLE;
                read      <= 1'b0;
                write     <= 1'b0;
                addr      <= 16'h0000;
                data_out  <= 8'h00;
                bus_abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && run) begin
                            wr_q     <= req_write;
                            rom_blk  <= rom_hit;
                            addr     <= req_addr;
                            data_out <= req_write ? req_wdata : 8'h00;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        read  <= !wr_q;
                        write <= wr_q && !rom_blk;
                        cnt   <= W - 4'd1;
                        state <= STROBE;
                    end
                    STROBE: begin
                        if (cnt == 4'd0) begin
                            read  <= 1'b0;
                            write <= 1'b0;
                            if (!wr_q) begin
                                rsp_rdata <= data_in;
                            end
                            state <= HOLD;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    HOLD: begin
                        rsp_valid <= 1'b1;
`ifdef MEM_BUS_ROM_PROTECT_EN
                        rom_wr_err <= wr_q && rom_blk;
`endif
                        state <= DONE;
                    end
                    DONE: begin
                        addr     <= 16'h0000;
                        data_out <= 8'h00;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
